// File: rtl/sgd_weight_update.sv
// SGD weight-update engine: collects one gradient per weight, then applies
// w <- sat(w - (g >>> LR_SHIFT)) to each weight in turn and counts passes.
module sgd_weight_update #(
  parameter int N_W      = 4,
  parameter int W_WIDTH  = 8,
  parameter int G_WIDTH  = 16,
  parameter int LR_SHIFT = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      init_i,
  input  logic [N_W*W_WIDTH-1:0]    init_w_i,
  input  logic                      grad_valid_i,
  output logic                      grad_ready_o,
  input  logic signed [G_WIDTH-1:0] grad_i,
  output logic [N_W*W_WIDTH-1:0]    w_o,
  output logic                      done_o,
  output logic                      busy_o,
  output logic                      sat_o,
  output logic [7:0]                epoch_o
);

  localparam int IDX_W = (N_W > 1) ? $clog2(N_W) : 1;
  localparam int SH_W  = G_WIDTH - LR_SHIFT;
  localparam int FW    = ((W_WIDTH > SH_W) ? W_WIDTH : SH_W) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_W - 1);
  localparam logic signed [W_WIDTH-1:0] W_MAX = {1'b0, {(W_WIDTH-1){1'b1}}};
  localparam logic signed [W_WIDTH-1:0] W_MIN = {1'b1, {(W_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_COLLECT, S_UPDATE, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q;
  logic signed [W_WIDTH-1:0]  w_q [N_W];
  logic signed [G_WIDTH-1:0]  g_q [N_W];
  logic                       sat_q;
  logic [7:0]                 epoch_q;

  logic                       accept;
  logic                       idx_last;
  logic signed [W_WIDTH-1:0]  w_cur;
  logic signed [G_WIDTH-1:0]  g_shift;
  logic signed [FW-1:0]       diff;
  logic                       pos_ovf, neg_ovf;
  logic signed [W_WIDTH-1:0]  w_new;

  assign accept   = grad_valid_i & grad_ready_o;
  assign idx_last = (idx_q == IDX_LAST);

  // Both operands are sign-extended (or the shifted gradient trimmed) to FW
  // bits, which is wide enough that the subtraction itself never overflows.
  assign w_cur    = w_q[idx_q];
  assign g_shift  = g_q[idx_q] >>> LR_SHIFT;
  assign diff     = FW'(w_cur) - FW'(g_shift);
  assign pos_ovf  = ~diff[FW-1] & (|diff[FW-2:W_WIDTH-1]);
  assign neg_ovf  =  diff[FW-1] & ~(&diff[FW-2:W_WIDTH-1]);
  assign w_new    = pos_ovf ? W_MAX : (neg_ovf ? W_MIN : diff[W_WIDTH-1:0]);

  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_i) state_q <= S_COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves state_d
    // unassigned, which would infer a latch.
    state_d = state_q;
    if (en_i) begin
      case (state_q)
        S_COLLECT: if (accept && idx_last) state_d = S_UPDATE;
        S_UPDATE:  if (idx_last)           state_d = S_DONE;
        S_DONE:                            state_d = S_COLLECT;
        default:                           state_d = S_COLLECT;
      endcase
    end
  end

  always_comb begin
    grad_ready_o = rst_i & en_i & ~init_i & (state_q == S_COLLECT);
    busy_o       = (state_q == S_UPDATE) | (state_q == S_DONE);
    done_o       = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx_q   <= '0;
      sat_q   <= 1'b0;
      epoch_q <= '0;
      // NOTE: the weight and gradient arrays are reset deliberately so an
      // aborted pass leaves nothing behind; this forces flops, not RAM.
      for (int k = 0; k < N_W; k++) begin
        w_q[k] <= '0;
        g_q[k] <= '0;
      end
    end else if (en_i) begin
      case (state_q)
        S_COLLECT: begin
          if (init_i) begin
            idx_q <= '0;
            sat_q <= 1'b0;
            for (int k = 0; k < N_W; k++) w_q[k] <= init_w_i[k*W_WIDTH +: W_WIDTH];
          end else if (accept) begin
            g_q[idx_q] <= grad_i;
            idx_q      <= idx_last ? '0 : idx_q + IDX_W'(1);
          end
        end
        S_UPDATE: begin
          w_q[idx_q] <= w_new;
          if (pos_ovf || neg_ovf) sat_q <= 1'b1;
          idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
          // Count the pass as it enters DONE so epoch_o is current with done_o.
          if (idx_last) epoch_q <= epoch_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < N_W; k++) begin : g_pack
    assign w_o[k*W_WIDTH +: W_WIDTH] = w_q[k];
  end

  assign sat_o   = sat_q;
  assign epoch_o = epoch_q;

endmodule

// File: tb/tb_sgd_weight_update.sv
// Scoreboard bench for sgd_weight_update: stimulus pushes expected pass
// results, a monitor pops and compares whenever done_o rises.
module tb_sgd_weight_update;

  logic        clk = 1'b0;
  logic        rst_i, en_i, init_i, grad_valid_i, grad_ready_o;
  logic [31:0] init_w_i, w_o;
  logic [15:0] grad_i;
  logic        done_o, busy_o, sat_o;
  logic [7:0]  epoch_o;

  always #5 clk = ~clk;

  sgd_weight_update #(.N_W(4), .W_WIDTH(8), .G_WIDTH(16), .LR_SHIFT(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .init_i(init_i), .init_w_i(init_w_i),
    .grad_valid_i(grad_valid_i), .grad_ready_o(grad_ready_o), .grad_i(grad_i),
    .w_o(w_o), .done_o(done_o), .busy_o(busy_o), .sat_o(sat_o), .epoch_o(epoch_o)
  );

  typedef struct {
    logic [31:0] w;
    logic        sat;
    logic [7:0]  epoch;
    bit          chk_lat;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_beat_cyc = 0;
  logic prev_done = 1'b0;
  logic en_seen = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_seen <= en_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [63:0] gp(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  // Monitor: one comparison set per pass, plus a done_o width check.
  always @(negedge clk) begin
    if (!rst_i) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done && en_seen) check("done_width", {31'b0, done_o}, 32'd0);
      if (done_o && !prev_done) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: done_o=1 with no pass expected (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("pass_w",     w_o,               e.w);
          check("pass_sat",   {31'b0, sat_o},    {31'b0, e.sat});
          check("pass_epoch", {24'b0, epoch_o},  {24'b0, e.epoch});
          if (e.chk_lat) check("done_latency", cyc - last_beat_cyc, 32'd4);
        end
      end
      prev_done = done_o;
    end
  end

  task automatic do_init(input logic [31:0] w);
    @(negedge clk);
    init_i   = 1'b1;
    init_w_i = w;
    @(negedge clk);
    init_i   = 1'b0;
  endtask

  task automatic beat(input logic [15:0] g);
    @(negedge clk);
    grad_valid_i = 1'b1;
    grad_i       = g;
    @(posedge clk);
    #1;
    grad_valid_i = 1'b0;
  endtask

  task automatic send_pass(input logic [63:0] gs);
    for (int k = 0; k < 4; k++) beat(gs[k*16 +: 16]);
    last_beat_cyc = cyc;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < 40);
    if (!done_o) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done_o within %0d cycles", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; en_i = 1'b1; init_i = 1'b0; init_w_i = '0;
    grad_valid_i = 1'b1; grad_i = 16'h1234;
    repeat (2) @(negedge clk);
    check("rst_w",     w_o,               32'd0);
    check("rst_done",  {31'b0, done_o},   32'd0);
    check("rst_sat",   {31'b0, sat_o},    32'd0);
    check("rst_epoch", {24'b0, epoch_o},  32'd0);
    check("rst_busy",  {31'b0, busy_o},   32'd0);
    check("rst_ready", {31'b0, grad_ready_o}, 32'd0);
    rst_i = 1'b1;
    grad_valid_i = 1'b0;
    #1;
    check("ready_after_rst", {31'b0, grad_ready_o}, 32'd1);

    // Back-to-back beats: {1,2,3,4} - {1,2,3,4} = 0.
    do_init(pack4(1, 2, 3, 4));
    sb_q.push_back('{w: pack4(0, 0, 0, 0), sat: 1'b0, epoch: 8'd1, chk_lat: 1'b1});
    send_pass(gp(16, 32, 48, 64));
    wait_done();

    // Positive saturation, then init clears sat_o.
    do_init(pack4(127, 0, 0, 0));
    sb_q.push_back('{w: pack4(127, 0, 0, 0), sat: 1'b1, epoch: 8'd2, chk_lat: 1'b1});
    send_pass(gp(-32768, 0, 0, 0));
    wait_done();
    do_init(pack4(-128, 5, 0, 0));
    check("sat_clear_init", {31'b0, sat_o}, 32'd0);
    check("init_load", w_o, pack4(-128, 5, 0, 0));

    // Negative saturation plus rounding of a negative gradient: 5 - (-2) = 7.
    sb_q.push_back('{w: pack4(-128, 7, 0, 0), sat: 1'b1, epoch: 8'd3, chk_lat: 1'b1});
    send_pass(gp(32767, -17, 0, 0));
    wait_done();

    // Gapped beats, enable drops in COLLECT, UPDATE and DONE.
    do_init(pack4(1, 2, 3, 4));
    sb_q.push_back('{w: pack4(0, 0, 0, 0), sat: 1'b0, epoch: 8'd4, chk_lat: 1'b0});
    beat(16'd16);
    @(negedge clk);
    grad_valid_i = 1'b1; grad_i = 16'd32; en_i = 1'b0;
    #1;
    check("ready_en_low", {31'b0, grad_ready_o}, 32'd0);
    repeat (3) @(negedge clk);
    en_i = 1'b1;
    @(posedge clk);
    #1;
    grad_valid_i = 1'b0;
    @(negedge clk);
    beat(16'd48);
    beat(16'd64);
    check("ready_in_update", {31'b0, grad_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    en_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_en_low", {31'b0, busy_o}, 32'd1);
    check("w_frozen",    w_o, pack4(0, 2, 3, 4));
    en_i = 1'b1;
    wait_done();
    en_i = 1'b0;
    repeat (2) @(negedge clk);
    check("done_held", {31'b0, done_o}, 32'd1);
    en_i = 1'b1;

    // Reset mid-UPDATE at idx 2 aborts the pass.
    do_init(pack4(1, 2, 3, 4));
    send_pass(gp(16, 32, 48, 64));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("abort_w",     w_o,              32'd0);
    check("abort_done",  {31'b0, done_o},  32'd0);
    check("abort_sat",   {31'b0, sat_o},   32'd0);
    check("abort_epoch", {24'b0, epoch_o}, 32'd0);
    check("abort_busy",  {31'b0, busy_o},  32'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("ready_post_abort", {31'b0, grad_ready_o}, 32'd1);
    repeat (8) @(negedge clk);

    // 256 passes: epoch wraps; init during UPDATE and DONE is ignored.
    do_init(pack4(10, 20, 30, 40));
    sb_q.push_back('{w: pack4(9, 19, 29, 39), sat: 1'b0, epoch: 8'd1, chk_lat: 1'b1});
    send_pass(gp(16, 16, 16, 16));
    init_i = 1'b1;
    init_w_i = pack4(100, 100, 100, 100);
    #1;
    check("ready_init_update", {31'b0, grad_ready_o}, 32'd0);
    wait_done();
    @(posedge clk);
    #1;
    init_i = 1'b0;
    for (int p = 2; p <= 256; p++) begin
      sb_q.push_back('{w: pack4(9, 19, 29, 39), sat: 1'b0, epoch: p[7:0], chk_lat: 1'b1});
      send_pass(64'd0);
      wait_done();
    end
    @(negedge clk);
    check("sb_drained",  sb_q.size(),      32'd0);
    check("epoch_wrap",  {24'b0, epoch_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sgd_weight_update.md
SGD_WEIGHT_UPDATE -- requirements
Module: sgd_weight_update

Interface
REQ-001 SHALL have parameter N_W, default 4: number of weights held and updated.
REQ-002 SHALL have parameter W_WIDTH, default 8: signed weight width.
REQ-003 SHALL have parameter G_WIDTH, default 16: signed gradient width.
REQ-004 SHALL have parameter LR_SHIFT, default 4: learning rate as an arithmetic right-shift.
REQ-005 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port en_i, input, 1: global enable; when low, all state SHALL freeze.
REQ-008 SHALL have port init_i, input, 1: load the initial weights.
REQ-009 SHALL have port init_w_i, input, N_W*W_WIDTH: initial weights, with weight k at bits [k*W_WIDTH +: W_WIDTH].
REQ-010 SHALL have port grad_valid_i, input, 1: gradient beat valid.
REQ-011 SHALL have port grad_ready_o, output, 1: ready to accept a gradient beat.
REQ-012 SHALL have port grad_i, input, G_WIDTH: signed gradient for the current weight index.
REQ-013 SHALL have port w_o, output, N_W*W_WIDTH: current weights, same packing as init_w_i, driving the hidden-neuron weight inputs.
REQ-014 SHALL have port done_o, output, 1: one-cycle pulse when an update pass completes.
REQ-015 SHALL have port busy_o, output, 1: high while in the UPDATE or DONE state.
REQ-016 SHALL have port sat_o, output, 1: sticky flag, set when any update saturated.
REQ-017 SHALL have port epoch_o, output, 8: count of completed update passes.

Function
REQ-018 SHALL implement an FSM with states COLLECT, UPDATE and DONE, and with beat/weight index idx of width clog2(N_W).
REQ-019 COLLECT: grad_ready_o SHALL equal en_i AND NOT init_i; all other states SHALL hold grad_ready_o low.
REQ-020 A beat SHALL be accepted on a rising edge where grad_valid_i and grad_ready_o are both high; grad_i SHALL be stored in gradient slot idx, and idx SHALL increment.
REQ-021 When the beat with idx = N_W-1 is accepted, idx SHALL return to 0 and the next state SHALL be UPDATE.
REQ-022 UPDATE SHALL, on each enabled edge, set w[idx] to sat(w[idx] - (g[idx] >>> LR_SHIFT)).
REQ-023 UPDATE SHALL increment idx after each weight and SHALL go to DONE after idx = N_W-1, with idx returning to 0.
REQ-024 The subtraction SHALL be computed at full width, max(W_WIDTH, G_WIDTH-LR_SHIFT)+1 bits.
REQ-025 The result SHALL clamp to [-2^(W_WIDTH-1), 2^(W_WIDTH-1)-1], and sat_o SHALL be set whenever clamping occurs.
REQ-026 In DONE, done_o SHALL be high for exactly one cycle, and epoch_o SHALL increment, wrapping from 255 to 0.
REQ-027 DONE SHALL transition to COLLECT on the next enabled edge.
REQ-028 Latency: if the last beat is accepted at edge t, weights SHALL update at edges t+1 through t+N_W, and done_o SHALL be high in the cycle after edge t+N_W.
REQ-029 init_i in COLLECT SHALL load w from init_w_i, reset idx to 0, discard partial beats and clear sat_o.
REQ-030 init_i in UPDATE or DONE SHALL be ignored.
REQ-031 When init_i and grad_valid_i are high together, init SHALL win and no beat SHALL be accepted.
REQ-032 With en_i low, the FSM, idx, weights, sat_o and epoch_o SHALL hold; a pending done_o SHALL stay high until the next enabled edge.
REQ-033 w_o SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-034 While rst_i is low, the block SHALL asynchronously force: state COLLECT, idx 0, all weights 0, all gradient slots 0, done_o 0, sat_o 0, epoch_o 0.
REQ-035 grad_ready_o SHALL be low while rst_i is low.
REQ-036 Reset asserted mid-UPDATE SHALL abort the pass, with no partial-weight retention, no done_o pulse and no epoch_o increment.
REQ-037 After rst_i is released, grad_ready_o SHALL follow REQ-019 from the first edge.

Verification
REQ-038 SHALL cover: init {1,2,3,4}; grads 16,32,48,64 on back-to-back beats -> w_o {0,0,0,0}, done_o exactly 4 cycles after the last beat, epoch_o = 1, sat_o = 0.
REQ-039 SHALL cover: w0 = 127, grad0 = -32768 (others 0) -> w0 stays 127 and sat_o = 1; a following init_i -> sat_o = 0.
REQ-040 SHALL cover: w0 = -128, grad0 = 32767 -> w0 stays -128 and sat_o = 1; also w1 = 5, grad1 = -17 -> w1 = 7 (since -17 >>> 4 = -2).
REQ-041 SHALL cover: grad_valid_i toggling and en_i low for 3 cycles mid-COLLECT and mid-UPDATE -> same final weights as the back-to-back case, done_o one cycle wide.
REQ-042 SHALL cover: rst_i low during UPDATE at idx = 2 -> all outputs immediately 0, no done_o pulse, epoch_o = 0.
REQ-043 SHALL cover: 256 complete passes -> epoch_o wraps to 0; init_i asserted during UPDATE has no effect.
